fir_reg_bank: RTL and testbench

// Parametrised control/status register bank for the filter datapath: N_COEF signed coefficients,

---
 rtl/fir_reg_bank_if.sv | 30 +++
 rtl/fir_reg_bank.sv | 185 ++++++++++++++++++
 tb/tb_fir_reg_bank.sv | 362 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fir_reg_bank_if.sv
// Request/acknowledge register bus between a master and the filter register bank.
//   req      master -> slave  transaction request, held high until ack
//   wr_en    master -> slave  1 = write, 0 = read
//   addr     master -> slave  register address
//   wr_data  master -> slave  write data
//   ack      slave  -> master one-cycle completion pulse
//   err      slave  -> master transaction rejected (valid with ack)
//   rd_data  slave  -> master read data (valid with ack, 0 on writes/errors)
interface fir_reg_bank_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 8
);
  logic              req;
  logic              wr_en;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wr_data;
  logic              ack;
  logic              err;
  logic [DATA_W-1:0] rd_data;

  modport master (
    output req, wr_en, addr, wr_data,
    input  ack, err, rd_data
  );

  modport slave (
    input  req, wr_en, addr, wr_data,
    output ack, err, rd_data
  );
endinterface

// File: rtl/fir_reg_bank.sv
// Control/status register bank for the filter datapath. Coefficient, divider and
// decimation-ratio writes land in shadow registers; a CTRL write with the apply bit
// copies every shadow to the live outputs in one edge. Also holds conversion enable,
// a set-only lock, chip ID, an ADC snapshot and sticky status flags.
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   bus                 req/ack register bus (slave side)
//   I_adc_data/valid    ADC sample and strobe
//   O_coef              live coefficients, coef k at [k*DATA_W +: DATA_W]
//   O_coef_div          live divider
//   O_decimation_ratio  live CIC ratio
//   O_conv_en           conversion enable
// Map (C = N_COEF): 0..C-1 COEF | C DIV | C+1 DEC | C+2 ID | C+3 CTRL | C+4 ADC | C+5 STATUS
module fir_reg_bank #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned N_COEF  = 3,
  parameter logic [7:0]  CHIP_ID = 8'hA5
) (
  input  logic                     clk,
  input  logic                     rst,
  fir_reg_bank_if.slave            bus,
  input  logic [DATA_W-1:0]        I_adc_data,
  input  logic                     I_adc_valid,
  output logic [N_COEF*DATA_W-1:0] O_coef,
  output logic [DATA_W-1:0]        O_coef_div,
  output logic [1:0]               O_decimation_ratio,
  output logic                     O_conv_en
);

  localparam int unsigned A_DIV    = N_COEF;
  localparam int unsigned A_DEC    = N_COEF + 1;
  localparam int unsigned A_ID     = N_COEF + 2;
  localparam int unsigned A_CTRL   = N_COEF + 3;
  localparam int unsigned A_ADC    = N_COEF + 4;
  localparam int unsigned A_STATUS = N_COEF + 5;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_RESP     = 2'd1;
  localparam logic [1:0] ST_WAIT_REL = 2'd2;

  logic [1:0]        state;
  logic [1:0]        state_nxt;

  // Shadow registers
  logic [DATA_W-1:0] coef_sh [N_COEF];
  logic [DATA_W-1:0] div_sh;
  logic [1:0]        dec_sh;

  // Control / status state
  logic              lock_q;
  logic              err_sticky_q;
  logic              adc_overrun_q;
  logic              adc_unread_q;
  logic [DATA_W-1:0] adc_snap_q;

  // Decode
  logic              accept_c;
  logic [N_COEF-1:0] hit_coef_c;
  logic              hit_div_c;
  logic              hit_dec_c;
  logic              hit_id_c;
  logic              hit_ctrl_c;
  logic              hit_adc_c;
  logic              hit_status_c;
  logic              mapped_c;
  logic              lockable_c;
  logic              err_c;
  logic              wr_ok_c;
  logic              adc_rd_c;
  logic [DATA_W-1:0] rd_val_c;

  // Next-state logic: a request is taken only from IDLE, so a held req yields one ack
  always_comb begin
    state_nxt = state;
    accept_c  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.req) begin
          state_nxt = ST_RESP;
          accept_c  = 1'b1;
        end
      end
      ST_RESP:     state_nxt = ST_WAIT_REL;
      ST_WAIT_REL: begin
        if (!bus.req) state_nxt = ST_IDLE;
      end
      default:     state_nxt = ST_IDLE;
    endcase
  end

  // Address decode, access check and read mux
  always_comb begin
    hit_coef_c = '0;
    rd_val_c   = '0;
    for (int k = 0; k < N_COEF; k++) begin
      if (bus.addr == ADDR_W'(k)) begin
        hit_coef_c[k] = 1'b1;
        rd_val_c      = coef_sh[k];
      end
    end
    hit_div_c    = (bus.addr == ADDR_W'(A_DIV));
    hit_dec_c    = (bus.addr == ADDR_W'(A_DEC));
    hit_id_c     = (bus.addr == ADDR_W'(A_ID));
    hit_ctrl_c   = (bus.addr == ADDR_W'(A_CTRL));
    hit_adc_c    = (bus.addr == ADDR_W'(A_ADC));
    hit_status_c = (bus.addr == ADDR_W'(A_STATUS));

    if (hit_div_c)    rd_val_c = div_sh;
    if (hit_dec_c)    rd_val_c = DATA_W'(dec_sh);
    if (hit_id_c)     rd_val_c = DATA_W'(CHIP_ID);
    // Apply bit is a pulse and always reads back as 0
    if (hit_ctrl_c)   rd_val_c = DATA_W'({lock_q, O_conv_en});
    if (hit_adc_c)    rd_val_c = adc_snap_q;
    if (hit_status_c) rd_val_c = DATA_W'({adc_unread_q, adc_overrun_q, err_sticky_q});

    mapped_c   = (|hit_coef_c) | hit_div_c | hit_dec_c | hit_id_c |
                 hit_ctrl_c | hit_adc_c | hit_status_c;
    lockable_c = (|hit_coef_c) | hit_div_c | hit_dec_c;
    err_c      = !mapped_c ||
                 (bus.wr_en && (hit_id_c || hit_adc_c || (lockable_c && lock_q)));
    wr_ok_c    = accept_c && bus.wr_en && !err_c;
    adc_rd_c   = accept_c && !bus.wr_en && hit_adc_c;
  end

  // State, response and register updates
  always_ff @(posedge clk) begin
    if (rst) begin
      state              <= ST_IDLE;
      bus.ack            <= 1'b0;
      bus.err            <= 1'b0;
      bus.rd_data        <= '0;
      for (int k = 0; k < N_COEF; k++) coef_sh[k] <= '0;
      div_sh             <= '0;
      dec_sh             <= 2'd1;
      O_coef             <= '0;
      O_coef_div         <= '0;
      O_decimation_ratio <= 2'd1;
      O_conv_en          <= 1'b0;
      lock_q             <= 1'b0;
      err_sticky_q       <= 1'b0;
      adc_overrun_q      <= 1'b0;
      adc_unread_q       <= 1'b0;
      adc_snap_q         <= '0;
    end else begin
      state       <= state_nxt;
      bus.ack     <= accept_c;
      bus.err     <= accept_c && err_c;
      bus.rd_data <= (accept_c && !bus.wr_en && !err_c) ? rd_val_c : '0;

      if (wr_ok_c) begin
        for (int k = 0; k < N_COEF; k++) begin
          if (hit_coef_c[k]) coef_sh[k] <= bus.wr_data;
        end
        if (hit_div_c) div_sh <= bus.wr_data;
        if (hit_dec_c) dec_sh <= bus.wr_data[1:0];
        if (hit_ctrl_c) begin
          O_conv_en <= bus.wr_data[0];
          lock_q    <= lock_q | bus.wr_data[1];
          // Atomic apply: every live output takes its shadow on this edge
          if (bus.wr_data[2]) begin
            for (int k = 0; k < N_COEF; k++) O_coef[k*DATA_W +: DATA_W] <= coef_sh[k];
            O_coef_div         <= div_sh;
            O_decimation_ratio <= dec_sh;
          end
        end
      end

      // Sticky flags: clears first so a coincident hardware set wins
      if (wr_ok_c && hit_status_c && bus.wr_data[0]) err_sticky_q  <= 1'b0;
      if (wr_ok_c && hit_status_c && bus.wr_data[1]) adc_overrun_q <= 1'b0;
      if (accept_c && err_c) err_sticky_q <= 1'b1;

      // A read completing on the same edge as a new sample suppresses overrun
      if (I_adc_valid) begin
        if (adc_unread_q && !adc_rd_c) adc_overrun_q <= 1'b1;
        adc_snap_q   <= I_adc_data;
        adc_unread_q <= 1'b1;
      end else if (adc_rd_c) begin
        adc_unread_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fir_reg_bank.sv
// Self-checking bench for fir_reg_bank: directed scenarios plus randomized
// transactions compared against a behavioural register-map model.
module tb_fir_reg_bank;

  localparam int DW = 8;
  localparam int AW = 8;
  localparam int C  = 3;

  logic          clk;
  logic          rst;
  logic [DW-1:0] I_adc_data;
  logic          I_adc_valid;
  logic [C*DW-1:0] O_coef;
  logic [DW-1:0] O_coef_div;
  logic [1:0]    O_decimation_ratio;
  logic          O_conv_en;

  fir_reg_bank_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  fir_reg_bank #(.DATA_W(DW), .ADDR_W(AW), .N_COEF(C), .CHIP_ID(8'hA5)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .I_adc_data(I_adc_data),
    .I_adc_valid(I_adc_valid),
    .O_coef(O_coef),
    .O_coef_div(O_coef_div),
    .O_decimation_ratio(O_decimation_ratio),
    .O_conv_en(O_conv_en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // Outputs captured in the ack cycle of the latest transaction
  logic [C*DW-1:0] ack_coef;
  logic [DW-1:0]   ack_div;

  // Behavioural model of the register map
  logic [7:0] m_coef [C];
  logic [7:0] m_live_coef [C];
  logic [7:0] m_div, m_live_div, m_snap;
  logic [1:0] m_dec, m_live_dec;
  bit         m_conv, m_lock, m_errs, m_ovr, m_unread;

  task automatic m_reset();
    for (int k = 0; k < C; k++) begin m_coef[k] = 8'h00; m_live_coef[k] = 8'h00; end
    m_div = 8'h00; m_live_div = 8'h00; m_snap = 8'h00;
    m_dec = 2'd1; m_live_dec = 2'd1;
    m_conv = 0; m_lock = 0; m_errs = 0; m_ovr = 0; m_unread = 0;
  endtask

  task automatic model_txn(input bit wr, input int a, input logic [7:0] d,
                           input bit av, input logic [7:0] ad,
                           output logic e, output logic [7:0] r);
    bit is_coef  = (a < C);
    bit mapped   = (a <= C + 5);
    bit lockable = is_coef || a == C || a == C + 1;
    bit adc_rd   = 0;
    e = !mapped || (wr && (a == C + 2 || a == C + 4 || (lockable && m_lock)));
    r = 8'h00;
    if (e) m_errs = 1;
    else if (!wr) begin
      if (is_coef)         r = m_coef[a];
      else if (a == C)     r = m_div;
      else if (a == C + 1) r = {6'b0, m_dec};
      else if (a == C + 2) r = 8'hA5;
      else if (a == C + 3) r = {6'b0, m_lock, m_conv};
      else if (a == C + 4) begin r = m_snap; adc_rd = 1; end
      else                 r = {5'b0, m_unread, m_ovr, m_errs};
    end else begin
      if (is_coef)         m_coef[a] = d;
      else if (a == C)     m_div = d;
      else if (a == C + 1) m_dec = d[1:0];
      else if (a == C + 3) begin
        m_conv = d[0];
        if (d[1]) m_lock = 1;
        if (d[2]) begin
          for (int k = 0; k < C; k++) m_live_coef[k] = m_coef[k];
          m_live_div = m_div;
          m_live_dec = m_dec;
        end
      end else if (a == C + 5) begin
        if (d[0]) m_errs = 0;
        if (d[1]) m_ovr = 0;
      end
    end
    if (av) begin
      if (m_unread && !adc_rd) m_ovr = 1;
      m_snap = ad;
      m_unread = 1;
    end else if (adc_rd) m_unread = 0;
  endtask

  function automatic logic [C*DW-1:0] m_live_packed();
    logic [C*DW-1:0] p;
    for (int k = 0; k < C; k++) p[k*DW +: DW] = m_live_coef[k];
    return p;
  endfunction

  // Bus master: starts and ends at a falling edge; err/rd stay X if no ack arrives
  task automatic bus_xfer(input bit wr, input int a, input logic [7:0] d,
                          input bit av, input logic [7:0] ad, input int hold,
                          output logic e, output logic [7:0] r, output int acks);
    bit got = 0;
    e = 1'bx; r = 8'hxx; acks = 0;
    bus.req = 1'b1; bus.wr_en = wr; bus.addr = AW'(a); bus.wr_data = d;
    I_adc_valid = av; I_adc_data = ad;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk);
      I_adc_valid = 1'b0;
      if (bus.ack === 1'b1) begin
        got = 1; acks++;
        e = bus.err; r = bus.rd_data;
        ack_coef = O_coef; ack_div = O_coef_div;
      end
    end
    repeat (hold) begin
      @(negedge clk);
      if (bus.ack === 1'b1) acks++;
    end
    bus.req = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic txn(input bit wr, input int a, input logic [7:0] d,
                     input bit av, input logic [7:0] ad, input int hold,
                     output logic ee, output logic [7:0] er,
                     output logic e, output logic [7:0] r, output int acks);
    model_txn(wr, a, d, av, ad, ee, er);
    bus_xfer(wr, a, d, av, ad, hold, e, r, acks);
  endtask

  task automatic wr_reg(input int a, input logic [7:0] d, output logic e);
    logic ee; logic [7:0] er, r; int n;
    txn(1, a, d, 0, 8'h00, 0, ee, er, e, r, n);
  endtask

  task automatic rd_reg(input int a, output logic [7:0] r, output logic e);
    logic ee; logic [7:0] er; int n;
    txn(0, a, 8'h00, 0, 8'h00, 0, ee, er, e, r, n);
  endtask

  task automatic adc_pulse(input logic [7:0] d);
    if (m_unread) m_ovr = 1;
    m_snap = d; m_unread = 1;
    I_adc_valid = 1'b1; I_adc_data = d;
    @(negedge clk);
    I_adc_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; bus.req = 1'b0; I_adc_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    m_reset();
  endtask

  task automatic test_reset();
    logic e; logic [7:0] r, exp;
    do_reset();
    n_total++;
    if ({bus.ack, bus.err, bus.rd_data, O_coef, O_coef_div, O_decimation_ratio, O_conv_en} !==
        {1'b0, 1'b0, 8'h00, 24'h0, 8'h00, 2'd1, 1'b0})
      $display("FAIL reset_outputs ack=%b err=%b coef=%h div=%h dec=%0d conv=%b, expected 0/0/0/0/1/0",
               bus.ack, bus.err, O_coef, O_coef_div, O_decimation_ratio, O_conv_en);
    else n_pass++;
    for (int a = 0; a <= C + 5; a++) begin
      rd_reg(a, r, e);
      exp = (a == C + 1) ? 8'h01 : (a == C + 2) ? 8'hA5 : 8'h00;
      n_total++;
      if (e !== 1'b0 || r !== exp)
        $display("FAIL reset_read addr=%0d got err=%b rd=%h, expected err=0 rd=%h", a, e, r, exp);
      else n_pass++;
    end
  endtask

  task automatic test_apply();
    logic e; logic [7:0] r;
    wr_reg(1, 8'h7F, e);
    wr_reg(C, 8'h03, e);
    n_total++;
    if (O_coef !== 24'h0 || O_coef_div !== 8'h00)
      $display("FAIL pre_apply coef=%h div=%h, expected 0/0", O_coef, O_coef_div);
    else n_pass++;
    wr_reg(C + 3, 8'h04, e);
    n_total++;
    if (e !== 1'b0 || ack_coef[15:8] !== 8'h7F || ack_div !== 8'h03)
      $display("FAIL apply_ack err=%b coef1=%h div=%h, expected 0/7f/03", e, ack_coef[15:8], ack_div);
    else n_pass++;
    rd_reg(C + 3, r, e);
    n_total++;
    if (r !== 8'h00) $display("FAIL ctrl_apply_reads0 rd=%h, expected 00", r);
    else n_pass++;
  endtask

  task automatic test_lock();
    logic e; logic [7:0] r;
    wr_reg(C + 3, 8'h02, e);
    wr_reg(0, 8'h11, e);
    n_total++;
    if (e !== 1'b1) $display("FAIL locked_write err=%b, expected 1", e);
    else n_pass++;
    rd_reg(0, r, e);
    n_total++;
    if (r !== 8'h00) $display("FAIL locked_shadow rd=%h, expected 00", r);
    else n_pass++;
    rd_reg(C + 5, r, e);
    n_total++;
    if (r !== 8'h01) $display("FAIL status_sticky rd=%h, expected 01", r);
    else n_pass++;
    wr_reg(C + 5, 8'h01, e);
    rd_reg(C + 5, r, e);
    n_total++;
    if (r !== 8'h00) $display("FAIL status_w1c rd=%h, expected 00", r);
    else n_pass++;
    wr_reg(C + 3, 8'h01, e);
    rd_reg(C + 3, r, e);
    n_total++;
    if (r !== 8'h03 || O_conv_en !== 1'b1)
      $display("FAIL lock_stays rd=%h conv=%b, expected 03/1", r, O_conv_en);
    else n_pass++;
  endtask

  task automatic test_unmapped();
    logic ee, e; logic [7:0] er, r; int n;
    do_reset();
    txn(0, C + 9, 8'h00, 0, 8'h00, 5, ee, er, e, r, n);
    n_total++;
    if (e !== 1'b1 || r !== 8'h00 || n !== 1)
      $display("FAIL unmapped_hold err=%b rd=%h acks=%0d, expected 1/00/1", e, r, n);
    else n_pass++;
    wr_reg(C + 2, 8'h5A, e);
    n_total++;
    if (e !== 1'b1) $display("FAIL write_id err=%b, expected 1", e);
    else n_pass++;
    wr_reg(C + 4, 8'h5A, e);
    n_total++;
    if (e !== 1'b1) $display("FAIL write_adc err=%b, expected 1", e);
    else n_pass++;
  endtask

  task automatic test_adc();
    logic ee, e; logic [7:0] er, r; int n;
    do_reset();
    adc_pulse(8'h12);
    adc_pulse(8'h80);
    rd_reg(C + 5, r, e);
    n_total++;
    if (r !== 8'h06) $display("FAIL adc_overrun_status rd=%h, expected 06", r);
    else n_pass++;
    rd_reg(C + 4, r, e);
    n_total++;
    if (r !== 8'h80 || e !== 1'b0) $display("FAIL adc_snapshot rd=%h err=%b, expected 80/0", r, e);
    else n_pass++;
    rd_reg(C + 5, r, e);
    n_total++;
    if (r !== 8'h02) $display("FAIL adc_unread_clear rd=%h, expected 02", r);
    else n_pass++;
    wr_reg(C + 5, 8'h02, e);
    adc_pulse(8'h21);
    txn(0, C + 4, 8'h00, 1, 8'h33, 0, ee, er, e, r, n);
    n_total++;
    if (r !== 8'h21) $display("FAIL adc_coincident_old rd=%h, expected 21", r);
    else n_pass++;
    rd_reg(C + 5, r, e);
    n_total++;
    if (r !== 8'h04) $display("FAIL adc_coincident_status rd=%h, expected 04", r);
    else n_pass++;
    rd_reg(C + 4, r, e);
    n_total++;
    if (r !== 8'h33) $display("FAIL adc_coincident_new rd=%h, expected 33", r);
    else n_pass++;
  endtask

  task automatic test_random();
    logic ee, e; logic [7:0] er, r, d, ad; int n, a; bit wr, av;
    do_reset();
    for (int i = 0; i < 200; i++) begin
      a  = int'($urandom_range(0, C + 8));
      wr = 1'($urandom_range(0, 1));
      d  = 8'($urandom);
      if (a == C + 3) d[1] = ($urandom_range(0, 15) == 0);
      av = ($urandom_range(0, 3) == 0);
      ad = 8'($urandom);
      if ($urandom_range(0, 5) == 0) adc_pulse(8'($urandom));
      txn(wr, a, d, av, ad, 0, ee, er, e, r, n);
      n_total++;
      if (e !== ee || r !== er || n !== 1)
        $display("FAIL rand_resp #%0d wr=%0b addr=%0d got err=%b rd=%h acks=%0d, expected err=%b rd=%h acks=1",
                 i, wr, a, e, r, n, ee, er);
      else n_pass++;
      n_total++;
      if (O_coef !== m_live_packed() || O_coef_div !== m_live_div ||
          O_decimation_ratio !== m_live_dec || O_conv_en !== m_conv)
        $display("FAIL rand_live #%0d got coef=%h div=%h dec=%0d conv=%b, expected %h/%h/%0d/%b",
                 i, O_coef, O_coef_div, O_decimation_ratio, O_conv_en,
                 m_live_packed(), m_live_div, m_live_dec, m_conv);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    logic e; logic [7:0] r; int acks; bit seen;
    for (int pass = 0; pass < 2; pass++) begin
      wr_reg(0, 8'h55, e);
      wr_reg(C + 3, 8'h05, e);
      bus.req = 1'b1; bus.wr_en = 1'b0; bus.addr = AW'(C + 2);
      seen = 0;
      for (int i = 0; i < 8 && !seen; i++) begin
        @(negedge clk);
        if (bus.ack === 1'b1) seen = 1;
      end
      repeat (pass * 2) @(negedge clk);
      rst = 1'b1; bus.req = 1'b0;
      @(negedge clk);
      n_total++;
      if (!seen || {bus.ack, bus.err, bus.rd_data, O_coef, O_coef_div, O_decimation_ratio, O_conv_en} !==
                   {1'b0, 1'b0, 8'h00, 24'h0, 8'h00, 2'd1, 1'b0})
        $display("FAIL reset_mid pass=%0d seen=%0b ack=%b coef=%h div=%h dec=%0d conv=%b, expected ack then reset values",
                 pass, seen, bus.ack, O_coef, O_coef_div, O_decimation_ratio, O_conv_en);
      else n_pass++;
      rst = 1'b0;
      m_reset();
      acks = 0;
      repeat (3) begin
        @(negedge clk);
        if (bus.ack === 1'b1) acks++;
      end
      n_total++;
      if (acks !== 0) $display("FAIL reset_mid_noack pass=%0d acks=%0d, expected 0", pass, acks);
      else n_pass++;
      rd_reg(0, r, e);
      n_total++;
      if (r !== 8'h00) $display("FAIL reset_mid_coef pass=%0d rd=%h, expected 00", pass, r);
      else n_pass++;
      rd_reg(C + 3, r, e);
      n_total++;
      if (r !== 8'h00) $display("FAIL reset_mid_ctrl pass=%0d rd=%h, expected 00", pass, r);
      else n_pass++;
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.req = 1'b0; bus.wr_en = 1'b0; bus.addr = '0; bus.wr_data = '0;
    I_adc_valid = 1'b0; I_adc_data = '0;
    test_reset();
    test_apply();
    test_lock();
    test_unmapped();
    test_adc();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
